// File: rtl/control_unit_fsm.sv
// Multi-cycle control unit for the RV64I-subset datapath: sequences FETCH/DECODE/EXEC/MEM/WB
// and drives IR, PC, ALU, register-file and data-memory controls.
module control_unit_fsm #(
    parameter int         MEM_WAIT = 1,
    parameter logic [6:0] OP_R     = 7'b0110011,
    parameter logic [6:0] OP_I     = 7'b0010011,
    parameter logic [6:0] OP_LD    = 7'b0000011,
    parameter logic [6:0] OP_SD    = 7'b0100011,
    parameter logic [6:0] OP_BR    = 7'b1100011
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [3:0] alu_flags,
    output logic       ir_load,
    output logic       pc_load,
    output logic       pc_src,
    output logic       alu_src,
    output logic       rf_src,
    output logic       rf_we,
    output logic       d_mem_we,
    output logic [3:0] alu_cmd,
    output logic       illegal,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    state_t     state_q;
    logic [6:0] op_q;
    logic [2:0] f3_q;
    logic [3:0] wait_cnt;
    logic       carry_unused;

    assign carry_unused = alu_flags[2];
    assign state        = state_q;

    function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
        if (op == OP_R || op == OP_I || op == OP_LD || op == OP_SD) return 1'b1;
        if (op == OP_BR) return (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b101);
        return 1'b0;
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic [3:0] fl);
        logic lt;
        lt = fl[1] ^ fl[3];
        case (f3)
            3'b000:  return fl[0];
            3'b001:  return !fl[0];
            3'b100:  return lt;
            3'b101:  return !lt;
            default: return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            op_q     <= '0;
            f3_q     <= '0;
            wait_cnt <= '0;
        end else begin
            case (state_q)
                FETCH: state_q <= DECODE;
                DECODE: begin
                    op_q    <= opcode;
                    f3_q    <= funct3;
                    state_q <= is_legal(opcode, funct3) ? EXEC : FETCH;
                end
                EXEC: begin
                    wait_cnt <= '0;
                    if (op_q == OP_LD || op_q == OP_SD) state_q <= MEM;
                    else if (op_q == OP_R || op_q == OP_I) state_q <= WB;
                    else state_q <= FETCH;
                end
                MEM: begin
                    if (op_q == OP_SD) begin
                        state_q <= FETCH;
                    end else if (wait_cnt == 4'(MEM_WAIT - 1)) begin
                        state_q <= WB;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                WB:      state_q <= FETCH;
                default: state_q <= FETCH;
            endcase
        end
    end

    // Moore decode of state and latched instruction; DECODE must look at the live IR fields
    // because they are only latched at the end of that cycle. Held at zero during reset.
    always_comb begin
        ir_load  = 1'b0;
        pc_load  = 1'b0;
        pc_src   = 1'b0;
        alu_src  = 1'b0;
        rf_src   = 1'b0;
        rf_we    = 1'b0;
        d_mem_we = 1'b0;
        alu_cmd  = 4'b0000;
        illegal  = 1'b0;
        if (rst_n) begin
            case (state_q)
                FETCH: ir_load = 1'b1;
                DECODE: begin
                    if (!is_legal(opcode, funct3)) begin
                        illegal = 1'b1;
                        pc_load = 1'b1;
                    end
                end
                EXEC, WB: begin
                    if (op_q == OP_R) begin
                        alu_cmd = 4'b0010;
                    end else if (op_q == OP_I) begin
                        alu_cmd = 4'b0011;
                        alu_src = 1'b1;
                    end else if (op_q == OP_LD || op_q == OP_SD) begin
                        alu_src = 1'b1;
                    end else if (op_q == OP_BR) begin
                        alu_cmd = 4'b0001;
                    end
                    if (state_q == EXEC && op_q == OP_BR) begin
                        pc_load = 1'b1;
                        pc_src  = br_taken(f3_q, alu_flags);
                    end
                    if (state_q == WB) begin
                        rf_we   = 1'b1;
                        pc_load = 1'b1;
                        rf_src  = (op_q == OP_LD);
                    end
                end
                MEM: begin
                    alu_src = 1'b1;
                    if (op_q == OP_SD) begin
                        d_mem_we = 1'b1;
                        pc_load  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
